// File: rtl/mem_arbiter.sv
// Round-robin owner of the single main memory: I-cache fills vs D-cache fills/write-throughs.
// Grant lands the cycle after a request is seen in IDLE; requesters hold req until their done pulse.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_req,
  input  logic [15:0]      icache_addr,
  input  logic             dcache_req,
  input  logic             dcache_wr,
  input  logic [15:0]      dcache_addr,
  input  logic [15:0]      dcache_wdata,
  output logic             icache_grant,
  output logic             dcache_grant,
  output logic [15:0]      fill_data,
  output logic [IDX_W-1:0] fill_idx,
  output logic             icache_fill_valid,
  output logic             dcache_fill_valid,
  output logic             icache_done,
  output logic             dcache_done,
  output logic [15:0]      mem_addr,
  output logic             mem_enable,
  output logic             mem_wr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_data_valid
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  localparam logic [IDX_W:0]   N_WORDS  = (IDX_W+1)'(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  state_t           state;
  logic             owner_d;
  logic             d_next;
  logic [15:1]      addr_q;
  logic [15:0]      wdata_q;
  logic [IDX_W:0]   issue_cnt;
  logic [IDX_W-1:0] recv_cnt;
  logic             grant_d;
  logic             issuing;
  logic             last_beat;
  logic             unused_addr_lsb;

  // Byte-address bit 0 never reaches memory; all accesses are word aligned.
  assign unused_addr_lsb = icache_addr[0] ^ dcache_addr[0];

  assign grant_d   = dcache_req && (!icache_req || d_next);
  assign issuing   = (state == FILL) && (issue_cnt < N_WORDS);
  assign last_beat = (state == FILL) && mem_data_valid && (recv_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      d_next    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (icache_req || dcache_req) begin
            owner_d   <= grant_d;
            d_next    <= !grant_d;
            addr_q    <= grant_d ? dcache_addr[15:1] : icache_addr[15:1];
            wdata_q   <= dcache_wdata;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= (grant_d && dcache_wr) ? WRITE : FILL;
          end
        end
        FILL: begin
          if (issuing)
            issue_cnt <= issue_cnt + 1'b1;
          if (last_beat) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end else if (mem_data_valid) begin
            recv_cnt <= recv_cnt + 1'b1;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    icache_grant      = (state != IDLE) && !owner_d;
    dcache_grant      = (state != IDLE) && owner_d;
    fill_data         = '0;
    fill_idx          = '0;
    icache_fill_valid = 1'b0;
    dcache_fill_valid = 1'b0;
    icache_done       = 1'b0;
    dcache_done       = 1'b0;
    mem_addr          = '0;
    mem_enable        = 1'b0;
    mem_wr            = 1'b0;
    mem_wdata         = '0;
    case (state)
      FILL: begin
        if (issuing) begin
          mem_enable = 1'b1;
          mem_addr   = {addr_q[15:1+IDX_W], issue_cnt[IDX_W-1:0], 1'b0};
        end
        if (mem_data_valid) begin
          fill_data         = mem_rdata;
          fill_idx          = recv_cnt;
          icache_fill_valid = !owner_d;
          dcache_fill_valid = owner_d;
          icache_done       = last_beat && !owner_d;
          dcache_done       = last_beat && owner_d;
        end
      end
      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {addr_q, 1'b0};
        mem_wdata   = wdata_q;
        dcache_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
